// File: rtl/interval_timer_if.sv
// interval_timer_if: control and status bundle between the game-control FSM and the interval timer
interface interval_timer_if #(
    parameter int WIDTH = 16,
    parameter int WRAPW = 8
) ();
    logic             go;
    logic             en;
    logic             hold;
    logic             down;
    logic             reload;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             done;
    logic             running;
    logic [WRAPW-1:0] wraps;
    modport master (
        output go, en, hold, down, reload, limit,
        input  count, done, running, wraps
    );
    modport slave (
        input  go, en, hold, down, reload, limit,
        output count, done, running, wraps
    );
endinterface

// File: rtl/interval_timer.sv
// interval_timer: up/down tick counter to a run-time limit, one-shot or auto-reload, with hold and saturating wrap count
module interval_timer #(
    parameter int WIDTH    = 16,
    parameter int MAXCOUNT = 35264,
    parameter int WRAPW    = 8
) (
    input  logic            clk,
    input  logic            resetn,
    interval_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, HOLD, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n, lim, lim_n, lim_in, start, term;
    logic [WRAPW-1:0] wraps, wraps_n;
    logic             dn, dn_n, rl, rl_n, done, done_n, running;
    assign lim_in = bus.limit == '0 ? WIDTH'(MAXCOUNT) : bus.limit;
    assign start  = dn ? lim : '0;
    assign term   = dn ? '0 : lim;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            lim     <= WIDTH'(MAXCOUNT);
            wraps   <= '0;
            dn      <= 1'b0;
            rl      <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lim     <= lim_n;
            wraps   <= wraps_n;
            dn      <= dn_n;
            rl      <= rl_n;
            done    <= done_n;
            running <= state_n == COUNT || state_n == HOLD;
        end
    end
    // go restarts from any state and outranks hold, en and terminal events
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lim_n   = lim;
        wraps_n = wraps;
        dn_n    = dn;
        rl_n    = rl;
        done_n  = 1'b0;
        if (bus.go) begin
            state_n = COUNT;
            lim_n   = lim_in;
            dn_n    = bus.down;
            rl_n    = bus.reload;
            cnt_n   = bus.down ? lim_in : '0;
            wraps_n = '0;
        end else begin
            case (state)
                COUNT: begin
                    if (bus.hold) begin
                        state_n = HOLD;
                    end else if (bus.en) begin
                        if (cnt != term) begin
                            cnt_n = dn ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
                        end else begin
                            done_n = 1'b1;
                            if (rl) begin
                                cnt_n   = start;
                                wraps_n = &wraps ? wraps : wraps + WRAPW'(1);
                            end else begin
                                state_n = DONE;
                            end
                        end
                    end
                end
                HOLD:    state_n = bus.hold ? HOLD : COUNT;
                default: state_n = state;
            endcase
        end
    end
    assign bus.count   = cnt;
    assign bus.done    = done;
    assign bus.running = running;
    assign bus.wraps   = wraps;
endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Parametrised successor to the single-shot game counter. It counts enabled ticks up or down between 0 and a run-time limit, in either one-shot or auto-reload mode. It supports hold/resume, a one-cycle done pulse and a saturating reload counter. It sits between the tick/rate divider and the game-control FSM, which starts it with go and reacts to done.

Parameters:
WIDTH, 16, counter width in bits.
MAXCOUNT, 35264, default terminal value, used when limit input is 0; must be < 2^WIDTH.
WRAPW, 8, width of the reload (wrap) counter.

Ports:
clk  input  1  system clock, all state on rising edge.
resetn  input  1  asynchronous, active-low reset.
go  input  1  synchronous (re)start; samples limit/down/reload; highest priority after reset.
en  input  1  tick enable; count advances only on cycles with en=1.
hold  input  1  level pause; count frozen while high.
down  input  1  direction, sampled on go: 0=up (0→limit), 1=down (limit→0).
reload  input  1  mode, sampled on go: 0=one-shot, 1=auto-reload.
limit  input  WIDTH  terminal value, sampled on go; 0 means use MAXCOUNT.
count  output  WIDTH  current count value.
done  output  1  one-cycle pulse on terminal event.
running  output  1  high in COUNT and HOLD states.
wraps  output  WRAPW  number of reloads since last go, saturating.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; count=0; done=0; running=0; wraps=0; latched lim=MAXCOUNT; latched down=0, reload=0.
- States: IDLE, COUNT, HOLD, DONE. All outputs are registered.
- Latched values: lim = (limit==0) ? MAXCOUNT : limit. start = down ? lim : 0. term = down ? 0 : lim.
- go=1 in any state: on the next edge, latch lim/down/reload; count<=start; wraps<=0; done<=0; state<=COUNT. go overrides hold, en and terminal events in the same cycle.
- IDLE: count holds; running=0; only go leaves.
- COUNT, hold=1: state<=HOLD; count unchanged that cycle, even if en=1.
- COUNT, hold=0, en=1, count!=term: count<=count+1 (up) or count-1 (down).
- COUNT, hold=0, en=1, count==term:
  - done<=1 for exactly one cycle.
  - One-shot: state<=DONE; count stays at term.
  - Reload: count<=start; wraps<=wraps+1, saturating at 2^WRAPW-1; state stays COUNT.
- COUNT, en=0: no change.
- Terminal timing: the terminal event needs one further en tick while count==term. A full one-shot run therefore takes lim+1 en ticks from go to done, and the count visibly rests on term.
- HOLD: count, wraps frozen; running=1; hold=0 → COUNT on the next edge. en is ignored while in HOLD.
- DONE: running=0; count holds term; done=0 after the first cycle; only go leaves.
- done is 0 in every cycle except the single cycle after a terminal edge.
- No arithmetic wrap: count never passes term and never underflows below 0.
- resetn asserted mid-run: immediate return to reset values; lim reverts to MAXCOUNT.

Test Plan:
- Bench parameters: WIDTH=8, MAXCOUNT=10, WRAPW=2.
- Reset then go with limit=0, down=0, reload=0, en=1 continuous → count 0..10, rests at 10 for one tick; done pulses once on the 11th en edge; state DONE, running=0, count stays 10.
- go with limit=3, down=1, reload=1, en=1 → count 3,2,1,0,3,2,1,0,…; done pulses each time 0→3; wraps 1,2,3 then stays 3 (saturated).
- Up run limit=5; assert hold at count=2 for 4 cycles with en=1 → count stays 2 and running=1; after release count continues 3,4,5; done after 6 total en ticks outside hold.
- In COUNT at count=7 (limit=9), assert go, hold and en together → next cycle count=0, wraps=0, state COUNT; the hold is ignored that cycle.
- en toggled every other cycle, limit=4 up one-shot → count advances only on en cycles; done exactly 5 en ticks after go, never on en=0 cycles.
- Drop resetn asynchronously mid-count (count=6) → count=0, done=0, running=0 immediately, before the next clk edge; the following go with limit=0 uses MAXCOUNT=10.
